// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter with hold limit and decoded one-hot grant; grant visible 1 cycle after arbitration.
// Release costs a GAP plus an IDLE cycle; non-owner requests wait until IDLE and are never dropped while held.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] cur;
  logic [7:0] hold_cnt;

  logic [2:0] win_idx;
  logic       win_found;

  function automatic logic [7:0] decode3(input logic en, input logic [2:0] idx);
    decode3 = en ? (8'h01 << idx) : 8'h00;
  endfunction

  // Search upward from ptr, wrapping modulo 8; first hit wins.
  always_comb begin
    win_idx   = ptr;
    win_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && req[ptr + 3'(i)]) begin
        win_idx   = ptr + 3'(i);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cur       <= 3'd0;
      hold_cnt  <= 8'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            cur       <= win_idx;
            gnt_idx   <= win_idx;
            hold_cnt  <= 8'd1;
            gnt       <= decode3(1'b1, win_idx);
            gnt_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A request drop on the limit cycle is a plain release, so it is checked first.
          if (!req[cur] || hold_cnt == HOLD_LIM) begin
            state     <= GAP;
            ptr       <= cur + 3'd1;
            gnt       <= decode3(1'b0, cur);
            gnt_valid <= 1'b0;
            timeout   <= req[cur];
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: one instance at MAX_HOLD=15, one at MAX_HOLD=2.
module tb_rr_decode_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  typedef struct {
    logic [7:0] req;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_valid_a, gnt_valid_b;
  logic       timeout_a, timeout_b;

  always #5 clk = ~clk;

  rr_decode_arbiter #(.MAX_HOLD(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .gnt_idx(gnt_idx_a), .gnt_valid(gnt_valid_a), .timeout(timeout_a)
  );

  rr_decode_arbiter #(.MAX_HOLD(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_valid(gnt_valid_b), .timeout(timeout_b)
  );

  int   n_vec   = 0;
  int   n_miss  = 0;
  int   to_seen = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic exp_t mk(input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
    exp_t e;
    e.gnt = g;
    e.idx = i;
    e.vld = v;
    e.to  = t;
    return e;
  endfunction

  function automatic void add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] i,
                              input logic v, input logic t);
    vec_t x;
    x.req = r;
    x.e   = mk(g, i, v, t);
    tbl.push_back(x);
  endfunction

  function automatic exp_t obs(input bit sel);
    if (sel) return mk(gnt_b, gnt_idx_b, gnt_valid_b, timeout_b);
    return mk(gnt_a, gnt_idx_a, gnt_valid_a, timeout_a);
  endfunction

  task automatic compare(input string tag, input exp_t got, input exp_t ex);
    n_vec++;
    if (got !== ex) begin
      n_miss++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
               tag, got.gnt, got.idx, got.vld, got.to, ex.gnt, ex.idx, ex.vld, ex.to);
    end
    if (got.to === 1'b1) to_seen++;
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then score after the edge.
  task automatic run_vec(input string tag, input bit sel, input logic [7:0] r, input exp_t e);
    @(negedge clk);
    if (sel) req_b = r;
    else     req_a = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag, obs(sel), sb.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    // Ptr walk from reset: normal release, priority search, 1-cycle pulse, ignored extra requests, wrap 7->0.
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
    add(8'h18, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    add(8'h21, 8'h00, 3'd5, 1'b0, 1'b0);
    add(8'h21, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h20, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h20, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    add(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
    add(8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h01, 8'h00, 3'd7, 1'b0, 1'b0);
    add(8'h01, 8'h00, 3'd7, 1'b0, 1'b0);
    add(8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    compare("reset_a", obs(1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0));
    compare("reset_b", obs(1'b1), mk(8'h00, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("table[%0d]", i), 1'b0, tbl[i].req, tbl[i].e);

    // Held request at MAX_HOLD=15: 15 grant cycles, timeout in GAP, IDLE, regrant (17-cycle period).
    t0 = to_seen;
    for (int k = 1; k <= 40; k++) begin
      automatic int pos = (k - 1) % 17;
      run_vec("hold", 1'b0, 8'h10,
              mk((pos < 15) ? 8'h10 : 8'h00, 3'd4, pos < 15, pos == 15));
    end
    run_vec("hold_drop", 1'b0, 8'h00, mk(8'h00, 3'd4, 1'b0, 1'b0));
    run_vec("hold_idle", 1'b0, 8'h00, mk(8'h00, 3'd4, 1'b0, 1'b0));
    check_int("hold_timeouts", to_seen - t0, 2);

    // Request drops on exactly the limit cycle: plain release, no timeout.
    t0 = to_seen;
    for (int k = 1; k <= 15; k++)
      run_vec("bnd_hold", 1'b0, 8'h10, mk(8'h10, 3'd4, 1'b1, 1'b0));
    run_vec("bnd_release", 1'b0, 8'h00, mk(8'h00, 3'd4, 1'b0, 1'b0));
    run_vec("bnd_idle", 1'b0, 8'h00, mk(8'h00, 3'd4, 1'b0, 1'b0));
    check_int("bnd_timeouts", to_seen - t0, 0);

    // All requesting at MAX_HOLD=2: two grant cycles, timeout, IDLE, next index, wrapping to 0.
    t0 = to_seen;
    for (int k = 1; k <= 36; k++) begin
      automatic int pos = (k - 1) % 4;
      automatic logic [2:0] idx = 3'((k - 1) / 4);
      run_vec("round_robin", 1'b1, 8'hFF,
              mk((pos < 2) ? (8'h01 << idx) : 8'h00, idx, pos < 2, pos == 2));
    end
    check_int("rr_timeouts", to_seen - t0, 9);

    // Asynchronous reset in the middle of a grant.
    @(negedge clk);
    req_a = 8'h04;
    repeat (3) @(posedge clk);
    #1;
    compare("pre_reset_grant", obs(1'b0), mk(8'h04, 3'd2, 1'b1, 1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    compare("async_reset", obs(1'b0), mk(8'h00, 3'd0, 1'b0, 1'b0));
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("post_reset_grant", obs(1'b0), mk(8'h04, 3'd2, 1'b1, 1'b0));

    check_int("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Round-robin arbiter that shares one decoded grant bus among eight requesters. Each cycle it can select one requester, hold its grant while the request stays high (capped by a hold limit), and then advance priority. The winner's 3-bit index drives an enabled 3-to-8 decode stage to produce the one-hot grant vector. The block sits between requesting agents and any shared resource selected by a decoded enable line.

## Interface
- MAX_HOLD, default 15: maximum consecutive cycles in which one grant may stay asserted. Legal range is 1..255.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector, level-sensitive; bit i belongs to requester i.
- gnt  output  8  one-hot grant; gnt = decode(gnt_idx) when gnt_valid = 1, else 8'h00.
- gnt_idx  output  3  index of the current or last granted requester.
- gnt_valid  output  1  a grant is active; this is the decoder enable.
- timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- The FSM has three states: IDLE, GRANT and GAP. All outputs are registered.
- Internal registers:
  - ptr[2:0]: priority pointer.
  - cur[2:0]: current winner.
  - hold_cnt[7:0]: cycles the current grant has been held.
- IDLE:
  - If req == 0, remain in IDLE.
  - Otherwise the winner is the first set bit of req, searching upward from ptr and wrapping 7→0. Load cur = winner and hold_cnt = 1, then enter GRANT.
- GRANT:
  - gnt_valid = 1 and gnt = 1 << cur.
  - If req[cur] == 0: enter GAP and set ptr = cur + 1 (mod 8). This is a normal release.
  - Else if hold_cnt == MAX_HOLD: enter GAP, set ptr = cur + 1 (mod 8), and pulse timeout for one cycle. This is a forced release.
  - Else: increment hold_cnt.
- GAP:
  - Lasts exactly one cycle with gnt = 0 and gnt_valid = 0, then enter IDLE.
  - The gap guarantees a break-before-make cycle between owners.
- Request bits of non-granted requesters are ignored while in GRANT and GAP. Requests are sampled again only in IDLE.
- A requester that was force-released and still holds req high is treated as a normal requester. Because ptr has already moved past it, it has the lowest priority in the next arbitration.
- gnt_idx holds cur in every state. After a release it keeps the last winner until the next grant.
- Wrap-around: cur = 7 releases to ptr = 0. The priority search wraps modulo 8.
- Reset (asynchronous, at any time, including mid-grant):
  - state = IDLE, ptr = 0, cur = 0, hold_cnt = 0.
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
  - No grant survives a reset.

## Timing
- Grant latency: req seen high at IDLE edge k gives gnt valid after edge k, visible in cycle k+1.
- Normal release: req[cur] sampled low at edge k gives gnt = 0 from cycle k+1 (GAP). IDLE follows at k+2. The earliest next grant is visible at k+3.
- Forced release: the grant is visible for exactly MAX_HOLD cycles. timeout is high in the first GAP cycle only.
- Back-to-back ownership costs a minimum of 2 dead cycles between grants, consisting of GAP followed by IDLE arbitration.
- A single-cycle req pulse in IDLE still earns a 1-cycle grant. The request drop is seen at the next edge.
- Simultaneous release and hold limit (req[cur] low on the MAX_HOLD cycle) count as a normal release: no timeout pulse.
- gnt is never multi-hot and never nonzero while gnt_valid = 0.

## Test plan
- Reset mid-grant:
  - Stimulus: req = 8'h04, wait 3 cycles, pulse rst_n low for half a cycle.
  - Required response: gnt = 0, gnt_idx = 0 and gnt_valid = 0 immediately, asynchronously. The grant then restarts with gnt = 8'h04 one cycle after reset release.
- Round robin:
  - Stimulus: req = 8'hFF held, MAX_HOLD = 2.
  - Required response: grants cycle through 8'h01, 8'h02, …, 8'h80, 8'h01. Each grant lasts 2 cycles, timeout pulses after each, and wrap-around goes from 7 to 0.
- Priority search:
  - Stimulus: after requester 5 releases (ptr = 6), drive req = 8'h21.
  - Required response: requester 0 wins (gnt = 8'h01). Requester 5 wins next.
- Normal release:
  - Stimulus: req = 8'h08 for 4 cycles, then 0.
  - Required response: gnt = 8'h08 for 4 cycles, then 0 with no timeout pulse. State returns to IDLE with ptr = 4.
- Hold limit:
  - Stimulus: MAX_HOLD = 15, req = 8'h10 held for 40 cycles.
  - Required response: grant lasts 15 cycles, then timeout and 2 dead cycles, then a regrant to 4. The count of timeout pulses matches.
- Boundary:
  - Stimulus: drop req[cur] on exactly the MAX_HOLD cycle. Separately, issue a 1-cycle req pulse in IDLE.
  - Required response: no timeout pulse in the first case. The second case gives exactly a 1-cycle gnt.
